conv_array_controller: RTL and testbench

- Sequences a 16-cell array of binary conv cells that computes a 4x4 binary convolution over a 16x16 binary image held in SRAM, one output row at a time.
- Arbitrates the single SRAM read port between the weight fetch and the image-row fetches, and drives the cells' weight-load, go, data and index-pipeline inputs.
- Pops the returned negative flags, thresholds them, and writes 13-bit output rows back to SRAM.
- Sits between the top-level run/busy handshake and the cell array.

---
 rtl/conv_array_controller_if.sv | 35 +++
 rtl/conv_array_controller.sv | 143 ++++++++++++++
 tb/tb_conv_array_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_array_controller_if.sv
// Handshake, SRAM and cell-array signals of the conv array controller.
// master = controller side, slave = SRAM / cell array / run-busy host side.
interface conv_array_controller_if;
  logic        dut_run;
  logic        dut_busy;
  logic [11:0] sram_rd_addr;
  logic [15:0] sram_rd_data;
  logic        sram_wr_en;
  logic [11:0] sram_wr_addr;
  logic [15:0] sram_wr_data;
  logic        cell_load_weight;
  logic [15:0] cell_weight;
  logic        cell_go;
  logic [15:0] cell_data;
  logic        cell_idx_en;
  logic [11:0] cell_write_addr;
  logic [3:0]  cell_idx;
  logic [11:0] cell_write_addr_ret;
  logic [3:0]  cell_idx_ret;
  logic [15:0] cell_neg_flag;

  modport master (
    input  dut_run, sram_rd_data, cell_write_addr_ret, cell_idx_ret, cell_neg_flag,
    output dut_busy, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
           cell_load_weight, cell_weight, cell_go, cell_data, cell_idx_en,
           cell_write_addr, cell_idx
  );

  modport slave (
    output dut_run, sram_rd_data, cell_write_addr_ret, cell_idx_ret, cell_neg_flag,
    input  dut_busy, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
           cell_load_weight, cell_weight, cell_go, cell_data, cell_idx_en,
           cell_write_addr, cell_idx
  );
endinterface

// File: rtl/conv_array_controller.sv
// Sequences a 16-cell binary conv array over a 16x16 image, one 13-pixel output row per pass.
// Row 0 takes 20 cycles, later rows 17; dut_run is ignored while busy, all outputs registered.
module conv_array_controller #(
  parameter logic [11:0] WEIGHT_ADDR = 12'h000,
  parameter logic [11:0] IN_BASE     = 12'h001,
  parameter logic [11:0] OUT_BASE    = 12'h100,
  parameter int unsigned THRESH      = 8
) (
  input logic                       clock,
  input logic                       reset,
  conv_array_controller_if.master   bus
);
  localparam logic [4:0] LP_THRESH = 5'(THRESH);

  typedef enum logic [2:0] {IDLE, W_RD, W_LD, R_RD, R_WAIT, CONV, DRAIN, WRITE} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0][15:0] r_rowbuf, w_rowbuf_nxt;
  logic [3:0]  r_row, r_c, w_c_nxt;
  logic [1:0]  r_rd_cnt;
  logic        r_prev_rd, r_flag_vld;
  logic [15:0] r_acc, w_acc_nxt, w_win;
  logic [4:0]  w_cnt;

  logic        r_busy, r_wr_en, r_load, r_go, r_idx_en;
  logic [11:0] r_rd_addr, r_wr_addr, r_waddr;
  logic [15:0] r_wr_data, r_weight, r_data;
  logic [3:0]  r_idx;

  assign bus.dut_busy         = r_busy;
  assign bus.sram_rd_addr     = r_rd_addr;
  assign bus.sram_wr_en       = r_wr_en;
  assign bus.sram_wr_addr     = r_wr_addr;
  assign bus.sram_wr_data     = r_wr_data;
  assign bus.cell_load_weight = r_load;
  assign bus.cell_weight      = r_weight;
  assign bus.cell_go          = r_go;
  assign bus.cell_data        = r_data;
  assign bus.cell_idx_en      = r_idx_en;
  assign bus.cell_write_addr  = r_waddr;
  assign bus.cell_idx         = r_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.dut_run) w_state_nxt = W_RD;
      W_RD:    w_state_nxt = W_LD;
      W_LD:    w_state_nxt = R_RD;
      R_RD:    if (r_row != 4'd0 || r_rd_cnt == 2'd3) w_state_nxt = R_WAIT;
      R_WAIT:  w_state_nxt = CONV;
      CONV:    if (r_c == 4'd12) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = WRITE;
      WRITE:   w_state_nxt = (r_row == 4'd12) ? IDLE : R_RD;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Window and write data are taken from next-cycle values so the word
  // arriving this cycle is already visible to the registered outputs.
  always_comb begin
    w_rowbuf_nxt = r_prev_rd ? {bus.sram_rd_data, r_rowbuf[3:1]} : r_rowbuf;
    w_c_nxt      = (r_state == CONV) ? r_c + 4'd1 : 4'd0;
    w_win        = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w_win[4*i+j] = w_rowbuf_nxt[i][w_c_nxt + 4'(j)];
    w_cnt = '0;
    for (int k = 0; k < 16; k++)
      w_cnt = w_cnt + 5'(bus.cell_neg_flag[k]);
    w_acc_nxt = r_acc;
    if (r_flag_vld && bus.cell_idx_ret < 4'd13)
      w_acc_nxt[bus.cell_idx_ret] = (w_cnt <= LP_THRESH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rowbuf   <= '0;
      r_row      <= '0;
      r_c        <= '0;
      r_rd_cnt   <= '0;
      r_prev_rd  <= 1'b0;
      r_flag_vld <= 1'b0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_load     <= 1'b0;
      r_weight   <= '0;
      r_go       <= 1'b0;
      r_idx_en   <= 1'b0;
      r_data     <= '0;
      r_waddr    <= '0;
      r_idx      <= '0;
    end else begin
      r_busy     <= (w_state_nxt != IDLE);
      r_rowbuf   <= w_rowbuf_nxt;
      r_prev_rd  <= (r_state == R_RD);
      r_rd_cnt   <= (r_state == R_RD) ? r_rd_cnt + 2'd1 : 2'd0;
      r_c        <= w_c_nxt;
      r_flag_vld <= r_go;

      if (w_state_nxt == W_RD)
        r_row <= '0;
      else if (r_state == WRITE && w_state_nxt == R_RD)
        r_row <= r_row + 4'd1;

      if (w_state_nxt == W_RD)
        r_rd_addr <= WEIGHT_ADDR;
      else if (w_state_nxt == R_RD) begin
        if (r_state == W_LD)       r_rd_addr <= IN_BASE;
        else if (r_state == WRITE) r_rd_addr <= IN_BASE + 12'(r_row) + 12'd4;
        else                       r_rd_addr <= r_rd_addr + 12'd1;
      end

      r_load <= (r_state == W_LD);
      if (r_state == W_LD) r_weight <= bus.sram_rd_data;

      r_go     <= (w_state_nxt == CONV);
      r_idx_en <= (w_state_nxt == CONV);
      if (w_state_nxt == CONV) begin
        r_data  <= w_win;
        r_waddr <= OUT_BASE + 12'(r_row);
        r_idx   <= w_c_nxt;
      end

      r_wr_en <= (w_state_nxt == WRITE);
      if (w_state_nxt == WRITE) begin
        r_wr_addr <= bus.cell_write_addr_ret;
        r_wr_data <= w_acc_nxt;
        r_acc     <= '0;
      end else begin
        r_acc     <= w_acc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_conv_array_controller.sv
// Directed bench: SRAM and cell-array models (cell flag = weight ^ window bit, 1-cycle latency).
module tb_conv_array_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  conv_array_controller_if bus();

  conv_array_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:31];
  always @(posedge clock) bus.sram_rd_data <= mem[bus.sram_rd_addr[4:0]];

  logic [15:0] cell_w = '0;
  initial begin
    bus.cell_neg_flag       = '0;
    bus.cell_idx_ret        = '0;
    bus.cell_write_addr_ret = '0;
  end
  always @(posedge clock) begin
    if (bus.cell_load_weight) cell_w <= bus.cell_weight;
    if (bus.cell_go) begin
      bus.cell_neg_flag       <= cell_w ^ bus.cell_data;
      bus.cell_idx_ret        <= bus.cell_idx;
      bus.cell_write_addr_ret <= bus.cell_write_addr;
    end
  end

  int          busy_cyc = 0, run_starts = 0, overlap = 0;
  logic        busy_prev = 1'b0;
  logic [11:0] wr_addr_q[$];
  logic [15:0] wr_dat_q[$];
  logic [3:0]  idx_q[$];
  logic [15:0] dat_q[$];
  always @(negedge clock) begin
    if (bus.dut_busy) busy_cyc++;
    if (bus.dut_busy && !busy_prev) run_starts++;
    busy_prev = bus.dut_busy;
    if (bus.sram_wr_en) begin
      wr_addr_q.push_back(bus.sram_wr_addr);
      wr_dat_q.push_back(bus.sram_wr_data);
    end
    if (bus.sram_wr_en && bus.cell_load_weight) overlap++;
    if (bus.cell_go) begin
      idx_q.push_back(bus.cell_idx);
      dat_q.push_back(bus.cell_data);
    end
  end

  // kind: 0 zeros, 1 ones, 2 row r = 1<<r, 3 rows 0..5 ones, 4 every row 0x00FF
  task automatic set_image(input logic [15:0] w, input int kind);
    logic [15:0] one;
    one = 16'h0001;
    mem[0] = w;
    for (int r = 0; r < 16; r++)
      case (kind)
        0: mem[1+r] = 16'h0000;
        1: mem[1+r] = 16'hFFFF;
        2: mem[1+r] = one << r;
        3: mem[1+r] = (r < 6) ? 16'hFFFF : 16'h0000;
        default: mem[1+r] = 16'h00FF;
      endcase
  endtask

  task automatic pulse_run();
    @(posedge clock); #1 bus.dut_run = 1'b1;
    @(posedge clock); #1 bus.dut_run = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (!bus.dut_busy) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    bus.dut_run = 1'b0;
    #3;
    vec_cnt++; if (bus.dut_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", bus.dut_busy); end
    vec_cnt++; if (bus.sram_wr_en !== 1'b0) begin err_cnt++; $display("FAIL reset_wr_en got %b want 0", bus.sram_wr_en); end
    vec_cnt++; if (bus.cell_go !== 1'b0) begin err_cnt++; $display("FAIL reset_go got %b want 0", bus.cell_go); end
    vec_cnt++; if (bus.cell_load_weight !== 1'b0) begin err_cnt++; $display("FAIL reset_load got %b want 0", bus.cell_load_weight); end
    vec_cnt++; if (bus.sram_rd_addr !== 12'h000) begin err_cnt++; $display("FAIL reset_rd_addr got %h want 000", bus.sram_rd_addr); end
    vec_cnt++; if (bus.cell_data !== 16'h0000) begin err_cnt++; $display("FAIL reset_cell_data got %h want 0000", bus.cell_data); end
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
  endtask

  task automatic test_zero_run();
    int wb, bb; bit ok;
    set_image(16'h0000, 0);
    wb = wr_addr_q.size(); bb = busy_cyc;
    pulse_run();
    wait_idle(ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL zero_done timeout got busy %b want 0", bus.dut_busy); end
    vec_cnt++; if (wr_addr_q.size() - wb !== 13) begin err_cnt++; $display("FAIL zero_wr_count got %0d want 13", wr_addr_q.size() - wb); end
    vec_cnt++; if (busy_cyc - bb !== 226) begin err_cnt++; $display("FAIL zero_busy_len got %0d want 226", busy_cyc - bb); end
    for (int k = 0; k < 13 && wb + k < wr_addr_q.size(); k++) begin
      vec_cnt++; if (wr_addr_q[wb+k] !== 12'h100 + 12'(k)) begin err_cnt++; $display("FAIL zero_wr_addr[%0d] got %h want %h", k, wr_addr_q[wb+k], 12'h100 + 12'(k)); end
      vec_cnt++; if (wr_dat_q[wb+k] !== 16'h1FFF) begin err_cnt++; $display("FAIL zero_wr_data[%0d] got %h want 1fff", k, wr_dat_q[wb+k]); end
    end
    vec_cnt++; if (overlap !== 0) begin err_cnt++; $display("FAIL zero_load_wr_overlap got %0d want 0", overlap); end
  endtask

  task automatic test_threshold();
    logic [15:0] w_tab [3] = '{16'hFFFF, 16'h00FF, 16'h007F};
    int          k_tab [3] = '{0, 1, 1};
    logic [15:0] e_tab [3] = '{16'h0000, 16'h1FFF, 16'h0000};
    int wb; bit ok;
    for (int t = 0; t < 3; t++) begin
      set_image(w_tab[t], k_tab[t]);
      wb = wr_addr_q.size();
      pulse_run();
      wait_idle(ok);
      vec_cnt++; if (wr_addr_q.size() - wb !== 13) begin err_cnt++; $display("FAIL thresh%0d_wr_count got %0d want 13", t, wr_addr_q.size() - wb); end
      for (int k = 0; k < 13 && wb + k < wr_dat_q.size(); k++) begin
        vec_cnt++; if (wr_dat_q[wb+k] !== e_tab[t]) begin err_cnt++; $display("FAIL thresh%0d_wr_data[%0d] got %h want %h", t, k, wr_dat_q[wb+k], e_tab[t]); end
      end
    end
  endtask

  task automatic test_diag_window();
    int wb, gb; bit ok;
    set_image(16'h0000, 2);
    wb = wr_addr_q.size(); gb = idx_q.size();
    pulse_run();
    wait_idle(ok);
    vec_cnt++; if (idx_q.size() - gb !== 169) begin err_cnt++; $display("FAIL diag_go_count got %0d want 169", idx_q.size() - gb); end
    if (idx_q.size() - gb >= 14) begin
      vec_cnt++; if (dat_q[gb] !== 16'h8421) begin err_cnt++; $display("FAIL diag_data_r0c0 got %h want 8421", dat_q[gb]); end
      vec_cnt++; if (dat_q[gb+13] !== 16'h0842) begin err_cnt++; $display("FAIL diag_data_r1c0 got %h want 0842", dat_q[gb+13]); end
    end
    for (int k = 0; k < 169 && gb + k < idx_q.size(); k++) begin
      vec_cnt++; if (idx_q[gb+k] !== 4'(k % 13)) begin err_cnt++; $display("FAIL diag_idx[%0d] got %0d want %0d", k, idx_q[gb+k], k % 13); end
    end
    for (int k = 0; k < 13 && wb + k < wr_dat_q.size(); k++) begin
      vec_cnt++; if (wr_dat_q[wb+k] !== 16'h1FFF) begin err_cnt++; $display("FAIL diag_wr_data[%0d] got %h want 1fff", k, wr_dat_q[wb+k]); end
    end
  endtask

  task automatic test_row_and_column_patterns();
    int wb; bit ok;
    logic [15:0] exp;
    set_image(16'h0000, 3);
    wb = wr_addr_q.size();
    pulse_run();
    wait_idle(ok);
    vec_cnt++; if (wr_addr_q.size() - wb !== 13) begin err_cnt++; $display("FAIL rows_wr_count got %0d want 13", wr_addr_q.size() - wb); end
    for (int k = 0; k < 13 && wb + k < wr_dat_q.size(); k++) begin
      exp = (k < 4) ? 16'h0000 : 16'h1FFF;
      vec_cnt++; if (wr_dat_q[wb+k] !== exp) begin err_cnt++; $display("FAIL rows_wr_data[%0d] got %h want %h", k, wr_dat_q[wb+k], exp); end
    end
    set_image(16'h0000, 4);
    wb = wr_addr_q.size();
    pulse_run();
    wait_idle(ok);
    for (int k = 0; k < 13 && wb + k < wr_dat_q.size(); k++) begin
      vec_cnt++; if (wr_dat_q[wb+k] !== 16'h1FC0) begin err_cnt++; $display("FAIL cols_wr_data[%0d] got %h want 1fc0", k, wr_dat_q[wb+k]); end
    end
  endtask

  task automatic test_reset_midrun();
    int wb; bit ok, hit;
    set_image(16'h0000, 0);
    wb = wr_addr_q.size();
    pulse_run();
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (wr_addr_q.size() - wb == 5 && bus.cell_go) begin hit = 1'b1; break; end
    end
    vec_cnt++; if (!hit) begin err_cnt++; $display("FAIL midrun_row5_conv timeout got writes %0d want 5", wr_addr_q.size() - wb); end
    @(posedge clock); #3 reset = 1'b0;
    #1;
    vec_cnt++; if (bus.dut_busy !== 1'b0) begin err_cnt++; $display("FAIL midrun_busy got %b want 0", bus.dut_busy); end
    vec_cnt++; if (bus.cell_go !== 1'b0) begin err_cnt++; $display("FAIL midrun_go got %b want 0", bus.cell_go); end
    vec_cnt++; if (bus.cell_idx_en !== 1'b0) begin err_cnt++; $display("FAIL midrun_idx_en got %b want 0", bus.cell_idx_en); end
    vec_cnt++; if (bus.cell_write_addr !== 12'h000) begin err_cnt++; $display("FAIL midrun_waddr got %h want 000", bus.cell_write_addr); end
    vec_cnt++; if (bus.cell_idx !== 4'h0) begin err_cnt++; $display("FAIL midrun_idx got %h want 0", bus.cell_idx); end
    vec_cnt++; if (bus.sram_rd_addr !== 12'h000) begin err_cnt++; $display("FAIL midrun_rd_addr got %h want 000", bus.sram_rd_addr); end
    @(posedge clock); #3 reset = 1'b1;
    repeat (300) @(negedge clock);
    vec_cnt++; if (wr_addr_q.size() - wb !== 5) begin err_cnt++; $display("FAIL midrun_no_more_writes got %0d want 5", wr_addr_q.size() - wb); end
    wb = wr_addr_q.size();
    pulse_run();
    wait_idle(ok);
    vec_cnt++; if (wr_addr_q.size() - wb !== 13) begin err_cnt++; $display("FAIL midrun_rerun_count got %0d want 13", wr_addr_q.size() - wb); end
    if (wr_addr_q.size() - wb >= 13) begin
      vec_cnt++; if (wr_addr_q[wb+12] !== 12'h10C) begin err_cnt++; $display("FAIL midrun_rerun_last_addr got %h want 10c", wr_addr_q[wb+12]); end
    end
  endtask

  task automatic test_run_while_busy();
    int wb, bb, rb; bit ok;
    wb = wr_addr_q.size(); bb = busy_cyc; rb = run_starts;
    pulse_run();
    repeat (50) @(negedge clock);
    bus.dut_run = 1'b1;
    @(negedge clock);
    bus.dut_run = 1'b0;
    wait_idle(ok);
    repeat (5) @(negedge clock);
    vec_cnt++; if (wr_addr_q.size() - wb !== 13) begin err_cnt++; $display("FAIL busy_run_wr_count got %0d want 13", wr_addr_q.size() - wb); end
    vec_cnt++; if (busy_cyc - bb !== 226) begin err_cnt++; $display("FAIL busy_run_len got %0d want 226", busy_cyc - bb); end
    vec_cnt++; if (run_starts - rb !== 1) begin err_cnt++; $display("FAIL busy_run_starts got %0d want 1", run_starts - rb); end
  endtask

  task automatic test_back_to_back();
    int wb, bb; bit ok;
    wb = wr_addr_q.size(); bb = busy_cyc;
    @(posedge clock); #1 bus.dut_run = 1'b1;
    @(posedge clock);
    wait_idle(ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL b2b_first_done timeout got busy %b want 0", bus.dut_busy); end
    @(negedge clock);
    vec_cnt++; if (bus.dut_busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_restart got busy %b want 1", bus.dut_busy); end
    bus.dut_run = 1'b0;
    wait_idle(ok);
    vec_cnt++; if (wr_addr_q.size() - wb !== 26) begin err_cnt++; $display("FAIL b2b_wr_count got %0d want 26", wr_addr_q.size() - wb); end
    vec_cnt++; if (busy_cyc - bb !== 452) begin err_cnt++; $display("FAIL b2b_busy_len got %0d want 452", busy_cyc - bb); end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_threshold();
    test_diag_window();
    test_row_and_column_patterns();
    test_reset_midrun();
    test_run_while_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
